// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and async reset.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid, main_valid_d;
  logic             skid_valid, skid_valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] main_data, main_data_d;
  logic [WIDTH-1:0] skid_data, skid_data_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_xfer, out_xfer;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = occ_q;
  // Skid variant uses a registered ready; single-entry variant passes ready through.
  assign in_ready  = SKID ? ready_q : (!main_valid || out_ready);

  // Next-state for main/skid entries; flush overrides every handshake.
  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    ready_d      = ready_q;
    in_xfer      = in_valid && in_ready;
    out_xfer     = main_valid && out_ready;

    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE;
      ready_d      = 1'b1;
    end else if (skid_valid) begin
      // in_ready is low here, so only the skid->main refill can happen.
      if (out_xfer) begin
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
        skid_data_d  = BUBBLE;
        ready_d      = 1'b1;
      end
    end else if (in_xfer) begin
      if (!main_valid || out_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        ready_d      = 1'b0;
      end
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
    end

    occ_d = 2'(main_valid_d) + 2'(skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
      ready_q    <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_valid_d;
      main_data  <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      ready_q    <= ready_d;
      occ_q      <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: dut_a has the skid buffer,
// dut_b is the single-entry variant with combinational in_ready.
module tb_pipe_stage_reg;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] BUB = 16'hB0B0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic         b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  // Packed observation {out_valid, out_data, in_ready, occupancy}
  logic [W+3:0] a_obs, b_obs, exp;
  assign a_obs = {a_out_valid, a_out_data, a_in_ready, a_occ};
  assign b_obs = {b_out_valid, b_out_data, b_in_ready, b_occ};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h1234; a_out_ready = 1'b1;
    b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b0;
    step(); step();
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL reset_a got=%h want=%h", a_obs, exp); end
    n_cmp++; if (b_obs !== exp) begin n_fail++; $display("FAIL reset_b got=%h want=%h", b_obs, exp); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();
    a_in_valid = 1'b0;
    exp = {1'b1, 16'h1234, 1'b1, 2'd1};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL reset_release got=%h want=%h", a_obs, exp); end
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'(i);
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b want=1", i, a_in_ready); end
      step();
      exp = {1'b1, 16'(i), 1'b1, 2'd1};
      n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL stream[%0d] got=%h want=%h", i, a_obs, exp); end
    end
    a_in_valid = 1'b0;
    step();
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL stream_drain got=%h want=%h", a_obs, exp); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hAAAA;
    step();
    exp = {1'b1, 16'hAAAA, 1'b1, 2'd1};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_a got=%h want=%h", a_obs, exp); end
    a_in_data = 16'hBBBB;
    step();
    exp = {1'b1, 16'hAAAA, 1'b0, 2'd2};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_b got=%h want=%h", a_obs, exp); end
    a_in_data = 16'hCCCC;
    step();
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_hold got=%h want=%h", a_obs, exp); end
    a_out_ready = 1'b1;
    step();
    exp = {1'b1, 16'hBBBB, 1'b1, 2'd1};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_out_b got=%h want=%h", a_obs, exp); end
    step();
    a_in_valid = 1'b0;
    exp = {1'b1, 16'hCCCC, 1'b1, 2'd1};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_out_c got=%h want=%h", a_obs, exp); end
    step();
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL bp_empty got=%h want=%h", a_obs, exp); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h1111;
    step();
    a_in_data = 16'h2222;
    step();
    n_cmp++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL flush_fill got=%0d want=2", a_occ); end
    a_flush = 1'b1; a_in_data = 16'hDEAD;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL flush_full got=%h want=%h", a_obs, exp); end
    // Flush with one entry while in_ready is high: the offered beat is dropped too.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h5A5A;
    step();
    a_flush = 1'b1; a_in_data = 16'hBEEF;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL flush_one got=%h want=%h", a_obs, exp); end
    step();
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL flush_stays_empty got=%h want=%h", a_obs, exp); end
  endtask

  task automatic test_comb_ready();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h5555;
    #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL comb_empty_ready got=%b want=1", b_in_ready); end
    step();
    b_in_data = 16'h6666;
    #1;
    exp = {1'b1, 16'h5555, 1'b0, 2'd1};
    n_cmp++; if (b_obs !== exp) begin n_fail++; $display("FAIL comb_stall got=%h want=%h", b_obs, exp); end
    b_out_ready = 1'b1;
    #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL comb_ready_rise got=%b want=1", b_in_ready); end
    step();
    b_in_valid = 1'b0;
    exp = {1'b1, 16'h6666, 1'b1, 2'd1};
    n_cmp++; if (b_obs !== exp) begin n_fail++; $display("FAIL comb_replace got=%h want=%h", b_obs, exp); end
    step();
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (b_obs !== exp) begin n_fail++; $display("FAIL comb_drain got=%h want=%h", b_obs, exp); end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h3333;
    step();
    a_in_data = 16'h4444;
    step();
    a_in_valid = 1'b0;
    n_cmp++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL arst_fill got=%0d want=2", a_occ); end
    #1 a_rst_n = 1'b0;
    #1;
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL arst_immediate got=%h want=%h", a_obs, exp); end
    #1 a_rst_n = 1'b1;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h7777;
    step();
    a_in_valid = 1'b0;
    exp = {1'b1, 16'h7777, 1'b1, 2'd1};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL arst_new_beat got=%h want=%h", a_obs, exp); end
    step();
    exp = {1'b0, BUB, 1'b1, 2'd0};
    n_cmp++; if (a_obs !== exp) begin n_fail++; $display("FAIL arst_no_stale got=%h want=%h", a_obs, exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_comb_ready();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
